// File: rtl/pb_jtag_pkg.sv
// rtl/pb_jtag_pkg.sv - shared JTAG selection constants and helpers
package pb_jtag_pkg;

  // Selection code that routes the internal bypass register to TDO
  localparam int SEL_BYPASS = 0;

  // Width of a selection code able to address num_dr channels plus bypass
  function automatic int sel_width(input int num_dr);
    return $clog2(num_dr + 1);
  endfunction

endpackage

// File: rtl/pb_tdo_stage_if.sv
// rtl/pb_tdo_stage_if.sv - TAP-side signal bundle for the TDO output stage
interface pb_tdo_stage_if
  import pb_jtag_pkg::*;
#(
  parameter int NUM_DR = 4,
  parameter int SEL_W  = sel_width(NUM_DR)
) ();

  logic              tdi_i;
  logic              capture_dr_i;
  logic              shift_dr_i;
  logic              shift_ir_i;
  logic              update_ir_i;
  logic [SEL_W-1:0]  sel_i;
  logic              ir_tdo_i;
  logic [NUM_DR-1:0] dr_tdo_i;
  logic              tdo_o;
  logic              tdo_en_o;
  logic [SEL_W-1:0]  sel_q_o;
  logic              sel_err_o;

  // TAP controller / register side: drives state strobes and serial data
  modport master (
    output tdi_i, capture_dr_i, shift_dr_i, shift_ir_i, update_ir_i,
    output sel_i, ir_tdo_i, dr_tdo_i,
    input  tdo_o, tdo_en_o, sel_q_o, sel_err_o
  );

  // TDO stage side
  modport slave (
    input  tdi_i, capture_dr_i, shift_dr_i, shift_ir_i, update_ir_i,
    input  sel_i, ir_tdo_i, dr_tdo_i,
    output tdo_o, tdo_en_o, sel_q_o, sel_err_o
  );

endinterface

// File: rtl/pb_bypass_reg.sv
// rtl/pb_bypass_reg.sv - single-bit JTAG bypass register
module pb_bypass_reg (
  input  logic tck_i,
  input  logic trst_ni,
  input  logic tdi_i,
  input  logic capture_i,
  input  logic shift_i,
  output logic q_o
);

  logic r_q;

  // Capture clears the bit and wins over shift; shift samples TDI
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      r_q <= 1'b0;
    end else if (capture_i) begin
      r_q <= 1'b0;
    end else if (shift_i) begin
      r_q <= tdi_i;
    end
  end

  assign q_o = r_q;

endmodule

// File: rtl/pb_tdo_stage.sv
// rtl/pb_tdo_stage.sv - TDO source select and negedge retiming stage
module pb_tdo_stage
  import pb_jtag_pkg::*;
#(
  parameter int NUM_DR = 4,
  parameter int SEL_W  = sel_width(NUM_DR)
) (
  input  logic          tck_i,
  input  logic          trst_ni,
  pb_tdo_stage_if.slave tap
);

  // Highest legal selection code, one bit wider so out-of-range codes compare cleanly
  localparam logic [SEL_W:0]   LP_SEL_MAX = (SEL_W+1)'(NUM_DR);
  localparam logic [SEL_W-1:0] LP_SEL_BYP = SEL_W'(SEL_BYPASS);

  logic [SEL_W-1:0] r_sel_q;
  logic             r_sel_err;
  logic             r_tdo;
  logic             r_tdo_en;

  logic w_sel_oor;
  logic w_byp_capture;
  logic w_byp_shift;
  logic w_byp_q;
  logic w_dr_bit;
  logic w_tdo_next;

  assign w_sel_oor = ({1'b0, tap.sel_i} > LP_SEL_MAX);

  // Latch the selection on Update-IR; illegal codes fall back to bypass and flag an error
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      r_sel_q   <= LP_SEL_BYP;
      r_sel_err <= 1'b0;
    end else if (tap.update_ir_i) begin
      if (w_sel_oor) begin
        r_sel_q   <= LP_SEL_BYP;
        r_sel_err <= 1'b1;
      end else begin
        r_sel_q   <= tap.sel_i;
        r_sel_err <= 1'b0;
      end
    end
  end

  // Capture only matters while bypass is selected; shift always clocks the bypass bit
  assign w_byp_capture = tap.capture_dr_i & (r_sel_q == LP_SEL_BYP);
  assign w_byp_shift   = tap.shift_dr_i & ~tap.capture_dr_i;

  pb_bypass_reg u_bypass (
    .tck_i     (tck_i),
    .trst_ni   (trst_ni),
    .tdi_i     (tap.tdi_i),
    .capture_i (w_byp_capture),
    .shift_i   (w_byp_shift),
    .q_o       (w_byp_q)
  );

  // Pick the data-register channel addressed by the latched selection (code k -> channel k-1)
  always_comb begin
    w_dr_bit = 1'b0;
    for (int k = 0; k < NUM_DR; k++) begin
      if (r_sel_q == SEL_W'(k + 1)) begin
        w_dr_bit = tap.dr_tdo_i[k];
      end
    end
  end

  // Next TDO value: IR shift outranks DR shift; idle drives 0
  always_comb begin
    w_tdo_next = 1'b0;
    if (tap.shift_ir_i) begin
      w_tdo_next = tap.ir_tdo_i;
    end else if (tap.shift_dr_i) begin
      w_tdo_next = (r_sel_q == LP_SEL_BYP) ? w_byp_q : w_dr_bit;
    end
  end

  // Retime TDO and its enable on the falling edge so the pin never moves on a rising edge
  always_ff @(negedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      r_tdo    <= 1'b0;
      r_tdo_en <= 1'b0;
    end else begin
      r_tdo    <= w_tdo_next;
      r_tdo_en <= tap.shift_ir_i | tap.shift_dr_i;
    end
  end

  assign tap.tdo_o     = r_tdo;
  assign tap.tdo_en_o  = r_tdo_en;
  assign tap.sel_q_o   = r_sel_q;
  assign tap.sel_err_o = r_sel_err;

endmodule

// File: tb/tb_pb_tdo_stage.sv
// tb/tb_pb_tdo_stage.sv - self-checking bench for pb_tdo_stage
module tb_pb_tdo_stage;

  localparam int NUM_DR = 4;

  logic tck;
  logic trst_n;

  int n_vec;
  int n_mis;

  // Reference state
  int m_sel;
  bit m_err;
  bit m_byp;
  bit m_tdo;
  bit m_en;

  pb_tdo_stage_if #(.NUM_DR(NUM_DR)) tap ();

  pb_tdo_stage #(.NUM_DR(NUM_DR)) dut (
    .tck_i   (tck),
    .trst_ni (trst_n),
    .tap     (tap)
  );

  initial begin
    tck = 1'b0;
    forever #5 tck = ~tck;
  end

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_tdo();
    if (tap.shift_ir_i) return tap.ir_tdo_i;
    if (tap.shift_dr_i) begin
      if (m_sel == 0) return m_byp;
      return tap.dr_tdo_i[m_sel - 1];
    end
    return 1'b0;
  endfunction

  task automatic model_pos();
    if (tap.capture_dr_i && m_sel == 0) m_byp = 1'b0;
    else if (tap.shift_dr_i && !tap.capture_dr_i) m_byp = tap.tdi_i;
    if (tap.update_ir_i) begin
      if (int'(tap.sel_i) > NUM_DR) begin
        m_sel = 0;
        m_err = 1'b1;
      end else begin
        m_sel = int'(tap.sel_i);
        m_err = 1'b0;
      end
    end
  endtask

  task automatic neg_check();
    @(negedge tck);
    #1;
    m_tdo = exp_tdo();
    m_en  = tap.shift_ir_i | tap.shift_dr_i;
    chk("tdo_neg", {3'b0, tap.tdo_o}, {3'b0, m_tdo});
    chk("tdo_en_neg", {3'b0, tap.tdo_en_o}, {3'b0, m_en});
  endtask

  task automatic step();
    @(posedge tck);
    #1;
    chk("tdo_hold_pos", {3'b0, tap.tdo_o}, {3'b0, m_tdo});
    chk("tdo_en_hold_pos", {3'b0, tap.tdo_en_o}, {3'b0, m_en});
    model_pos();
    chk("sel_q", {1'b0, tap.sel_q_o}, 4'(m_sel));
    chk("sel_err", {3'b0, tap.sel_err_o}, {3'b0, m_err});
    neg_check();
  endtask

  task automatic idle_inputs();
    tap.tdi_i        = 1'b0;
    tap.capture_dr_i = 1'b0;
    tap.shift_dr_i   = 1'b0;
    tap.shift_ir_i   = 1'b0;
    tap.update_ir_i  = 1'b0;
    tap.sel_i        = '0;
    tap.ir_tdo_i     = 1'b0;
    tap.dr_tdo_i     = '0;
  endtask

  initial begin
    n_vec = 0;
    n_mis = 0;
    m_sel = 0; m_err = 0; m_byp = 0; m_tdo = 0; m_en = 0;
    trst_n = 1'b0;
    idle_inputs();
    #1;
    chk("rst_tdo", {3'b0, tap.tdo_o}, 4'd0);
    chk("rst_tdo_en", {3'b0, tap.tdo_en_o}, 4'd0);
    chk("rst_sel_q", {1'b0, tap.sel_q_o}, 4'd0);
    chk("rst_sel_err", {3'b0, tap.sel_err_o}, 4'd0);
    #11;
    trst_n = 1'b1;

    // Bypass: capture then shift 1,0,1
    tap.update_ir_i = 1'b1; tap.sel_i = 3'd0;
    step();
    tap.update_ir_i = 1'b0;
    tap.capture_dr_i = 1'b1; tap.shift_dr_i = 1'b1; tap.tdi_i = 1'b1;
    step();
    chk("byp_first", {3'b0, tap.tdo_o}, 4'd0);
    tap.capture_dr_i = 1'b0; tap.tdi_i = 1'b1;
    step();
    chk("byp_second", {3'b0, tap.tdo_o}, 4'd1);
    tap.tdi_i = 1'b0;
    step();
    chk("byp_third", {3'b0, tap.tdo_o}, 4'd0);
    tap.tdi_i = 1'b1;
    step();

    // Channel select 3
    tap.shift_dr_i = 1'b0; tap.update_ir_i = 1'b1; tap.sel_i = 3'd3;
    step();
    tap.update_ir_i = 1'b0; tap.shift_dr_i = 1'b1; tap.dr_tdo_i = 4'b0100;
    step();
    chk("ch3_one", {3'b0, tap.tdo_o}, 4'd1);
    tap.dr_tdo_i = 4'b1011;
    step();
    chk("ch3_zero", {3'b0, tap.tdo_o}, 4'd0);

    // Out-of-range selection
    tap.shift_dr_i = 1'b0; tap.update_ir_i = 1'b1; tap.sel_i = 3'd6;
    step();
    chk("oor_sel_q", {1'b0, tap.sel_q_o}, 4'd0);
    chk("oor_err", {3'b0, tap.sel_err_o}, 4'd1);
    tap.sel_i = 3'd2;
    step();
    chk("recover_err", {3'b0, tap.sel_err_o}, 4'd0);
    chk("recover_sel_q", {1'b0, tap.sel_q_o}, 4'd2);

    // IR shift outranks DR shift
    tap.update_ir_i = 1'b0;
    tap.shift_ir_i = 1'b1; tap.shift_dr_i = 1'b1; tap.ir_tdo_i = 1'b1; tap.dr_tdo_i = 4'b0000;
    step();
    chk("prio_tdo", {3'b0, tap.tdo_o}, 4'd1);
    chk("prio_en", {3'b0, tap.tdo_en_o}, 4'd1);
    tap.shift_ir_i = 1'b0; tap.shift_dr_i = 1'b0;
    step();
    chk("idle_tdo", {3'b0, tap.tdo_o}, 4'd0);
    chk("idle_en", {3'b0, tap.tdo_en_o}, 4'd0);

    // Selection updated while shifting governs the same negedge
    tap.shift_dr_i = 1'b1; tap.dr_tdo_i = 4'b0001;
    step();
    tap.update_ir_i = 1'b1; tap.sel_i = 3'd1;
    step();
    chk("upd_shift_tdo", {3'b0, tap.tdo_o}, 4'd1);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      tap.tdi_i        = 1'($urandom);
      tap.capture_dr_i = ($urandom_range(0, 7) == 0);
      tap.shift_dr_i   = 1'($urandom);
      tap.shift_ir_i   = ($urandom_range(0, 3) == 0);
      tap.update_ir_i  = ($urandom_range(0, 5) == 0);
      tap.sel_i        = 3'($urandom_range(0, 7));
      tap.ir_tdo_i     = 1'($urandom);
      tap.dr_tdo_i     = 4'($urandom);
      step();
    end

    // Asynchronous reset mid-shift with tdo high
    idle_inputs();
    tap.update_ir_i = 1'b1; tap.sel_i = 3'd3;
    step();
    tap.update_ir_i = 1'b0; tap.shift_ir_i = 1'b1; tap.ir_tdo_i = 1'b1;
    step();
    chk("pre_rst_tdo", {3'b0, tap.tdo_o}, 4'd1);
    #2;
    trst_n = 1'b0;
    #1;
    m_sel = 0; m_err = 0; m_byp = 0; m_tdo = 0; m_en = 0;
    chk("arst_tdo", {3'b0, tap.tdo_o}, 4'd0);
    chk("arst_tdo_en", {3'b0, tap.tdo_en_o}, 4'd0);
    chk("arst_sel_q", {1'b0, tap.sel_q_o}, 4'd0);
    chk("arst_sel_err", {3'b0, tap.sel_err_o}, 4'd0);
    @(posedge tck);
    #1;
    chk("in_rst_tdo", {3'b0, tap.tdo_o}, 4'd0);
    #1;
    tap.shift_ir_i = 1'b0; tap.shift_dr_i = 1'b1; tap.tdi_i = 1'b1;
    trst_n = 1'b1;
    neg_check();
    chk("post_rst_tdo", {3'b0, tap.tdo_o}, 4'd0);
    chk("post_rst_en", {3'b0, tap.tdo_en_o}, 4'd1);
    step();
    chk("post_rst_shift", {3'b0, tap.tdo_o}, 4'd1);
    idle_inputs();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/pb_tdo_stage.md
PB_TDO_STAGE -- requirements
Module: pb_tdo_stage

Interface
REQ-001 Parameter NUM_DR, default 4: number of data-register TDO channels, legal range 1..15.
REQ-002 Parameter SEL_W, default $clog2(NUM_DR+1): width of the selection code.
REQ-003 tck_i  input  1  sole clock, JTAG TCK; posedge and negedge of this one clock are used.
REQ-004 trst_ni  input  1  reset, asynchronous, active-low.
REQ-005 tdi_i  input  1  serial data into the internal bypass register.
REQ-006 capture_dr_i  input  1  TAP in Capture-DR.
REQ-007 shift_dr_i  input  1  TAP in Shift-DR.
REQ-008 shift_ir_i  input  1  TAP in Shift-IR.
REQ-009 update_ir_i  input  1  TAP in Update-IR; strobes sel_i into the selection register.
REQ-010 sel_i  input  SEL_W  decoded DR selection: 0 = bypass, k = dr_tdo_i[k-1].
REQ-011 ir_tdo_i  input  1  serial output of the instruction register.
REQ-012 dr_tdo_i  input  NUM_DR  serial outputs of the data-register channels.
REQ-013 tdo_o  output  1  retimed TDO.
REQ-014 tdo_en_o  output  1  TDO output enable, high only while shifting.
REQ-015 sel_q_o  output  SEL_W  currently latched selection.
REQ-016 sel_err_o  output  1  last Update-IR carried an out-of-range selection.

Function
REQ-017 At posedge tck_i with update_ir_i=1 and sel_i<=NUM_DR, sel_q SHALL load sel_i and sel_err SHALL clear.
REQ-018 At posedge tck_i with update_ir_i=1 and sel_i>NUM_DR, sel_q SHALL load 0 (bypass) and sel_err SHALL set.
REQ-019 Without update_ir_i, sel_q and sel_err SHALL hold.
REQ-020 The bypass register SHALL load 0 at posedge when capture_dr_i=1 and sel_q=0; it SHALL load tdi_i at posedge when shift_dr_i=1 and capture_dr_i=0; otherwise it SHALL hold. Capture has priority.
REQ-021 The combinational next-TDO SHALL be: ir_tdo_i if shift_ir_i=1; else, if shift_dr_i=1, the bypass register when sel_q=0 or dr_tdo_i[sel_q-1] otherwise; else 0. shift_ir_i has priority over shift_dr_i.
REQ-022 At every negedge tck_i, tdo_o SHALL load next-TDO and tdo_en_o SHALL load (shift_ir_i | shift_dr_i).
REQ-023 Latency: the state present after posedge k SHALL appear on tdo_o at the negedge immediately following (half a TCK period).
REQ-024 When update_ir_i and shift_dr_i are both high, the selection loaded at that posedge SHALL govern the following negedge.
REQ-025 sel_q_o SHALL equal sel_q. sel_err_o SHALL equal sel_err.
REQ-026 No combinational path SHALL exist from any input to tdo_o or tdo_en_o.

Reset
REQ-027 trst_ni=0 SHALL immediately force sel_q=0, sel_err=0, bypass register=0, tdo_o=0 and tdo_en_o=0, independent of tck_i.
REQ-028 Reset asserted mid-shift SHALL abort the shift. After release, the first negedge SHALL output per REQ-021, using the reset state.

Structure
REQ-029 Package pb_jtag_pkg SHALL hold the SEL_BYPASS constant (0) and a selection-width helper function. Both are shared with the IR decoder.
REQ-030 The bypass register SHALL be a separate sub-module pb_bypass_reg (tck_i, trst_ni, tdi_i, capture_i, shift_i, q_o).

Verification (NUM_DR=4)
REQ-031 Reset: trst_ni=0 mid-shift with tdo_o=1 -> tdo_o=0, tdo_en_o=0, sel_q_o=0 without any clock edge.
REQ-032 Bypass: sel_q=0, capture_dr then shift tdi_i=1,0,1 -> tdo_o=0,1,0 at successive negedges, each value changing only on a negedge.
REQ-033 Channel select: update_ir with sel_i=3, then shift_dr with dr_tdo_i=4'b0100 -> tdo_o=1; with dr_tdo_i=4'b1011 -> tdo_o=0.
REQ-034 Out of range: update_ir with sel_i=6 -> sel_q_o=0, sel_err_o=1; a later update_ir with sel_i=2 -> sel_err_o=0.
REQ-035 Priority: shift_ir_i=shift_dr_i=1 with ir_tdo_i=1 and selected DR=0 -> tdo_o=1 and tdo_en_o=1; both shift inputs low -> tdo_o=0, tdo_en_o=0 at the next negedge.
REQ-036 Timing: change dr_tdo_i between a negedge and the next posedge -> tdo_o changes only at the next negedge, never on a posedge.
